// File: rtl/balance_cntrl.sv
// balance_cntrl -- PID balance controller for a self-balancing platform.
//
// Turns a signed pitch error into left/right motor magnitude and direction.
// A PID sum, with optional steering from the load cells, is shaped into a
// motor command for each side.
//
// Ports:
//   clk          in   1   sole clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   vld          in   1   new pitch sample strobe (integrates and shifts the error queue)
//   ptch         in  16   signed pitch error
//   ld_cell_diff in  12   signed load-cell difference, used for steering
//   rider_off    in   1   rider absent; clears the integrator
//   en_steer     in   1   steering enable
//   lft_spd      out 11   left motor magnitude (unsigned, saturated)
//   lft_rev      out  1   left motor reverse
//   rght_spd     out 11   right motor magnitude (unsigned, saturated)
//   rght_rev     out  1   right motor reverse
//
// The outputs are combinational from the current inputs and the registered
// state (integrator and error queue). They are not registered.
module balance_cntrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic [11:0] ld_cell_diff,
  input  logic        rider_off,
  input  logic        en_steer,
  output logic [10:0] lft_spd,
  output logic        lft_rev,
  output logic [10:0] rght_spd,
  output logic        rght_rev
);

  localparam logic signed [14:0] P_COEFF         = 15'sd14;
  localparam logic signed [12:0] D_COEFF         = 13'sd20;
  localparam logic signed [16:0] LOW_TORQUE_BAND = 17'sd70;
  localparam logic signed [15:0] GAIN_MULTIPLIER = 16'sd15;
  localparam logic signed [15:0] MIN_DUTY        = 16'sd980;

  // Clamp the 16b pitch error into the 10b signed range.
  function automatic logic signed [9:0] sat10(input logic signed [15:0] v);
    if (v > 16'sd511) begin
      sat10 = 10'sd511;
    end else if (v < -16'sd512) begin
      sat10 = -10'sd512;
    end else begin
      sat10 = v[9:0];
    end
  endfunction

  // Clamp the 11b derivative difference into the 7b signed range.
  function automatic logic signed [6:0] sat7(input logic signed [10:0] v);
    if (v > 11'sd63) begin
      sat7 = 7'sd63;
    end else if (v < -11'sd64) begin
      sat7 = -7'sd64;
    end else begin
      sat7 = v[6:0];
    end
  endfunction

  // Torque shaping. Large torques get a fixed duty offset to overcome motor
  // dead band. Small torques get a high gain. A torque of exactly +/-70
  // takes the offset path.
  function automatic logic signed [15:0] shape(input logic signed [15:0] t);
    logic signed [16:0] t_ext;
    logic signed [16:0] t_abs;
    t_ext = {t[15], t};
    t_abs = t_ext[16] ? -t_ext : t_ext;
    if (t_abs >= LOW_TORQUE_BAND) begin
      if (t[15]) begin
        shape = t - MIN_DUTY;
      end else begin
        shape = t + MIN_DUTY;
      end
    end else begin
      shape = t * GAIN_MULTIPLIER;
    end
  endfunction

  // Magnitude of a shaped command, saturated to 11 bits.
  function automatic logic [10:0] mag11(input logic signed [15:0] c);
    logic signed [16:0] c_ext;
    logic signed [16:0] c_abs;
    c_ext = {c[15], c};
    c_abs = c_ext[16] ? -c_ext : c_ext;
    if (c_abs > 17'sd2047) begin
      mag11 = 11'h7FF;
    end else begin
      mag11 = c_abs[10:0];
    end
  endfunction

  logic signed [9:0]  err_sat_s;
  logic signed [14:0] p_term_s;
  logic signed [17:0] integ_r;
  logic signed [17:0] err_ext_s;
  logic signed [17:0] integ_sum_s;
  logic               integ_ovf_s;
  logic signed [14:0] i_term_s;
  logic signed [9:0]  q1_r;
  logic signed [9:0]  q2_r;
  logic signed [10:0] d_diff_s;
  logic signed [6:0]  d_sat_s;
  logic signed [12:0] d_term_s;
  logic signed [15:0] pid_s;
  logic signed [15:0] steer_s;
  logic signed [15:0] lft_torque_s;
  logic signed [15:0] rght_torque_s;
  logic signed [15:0] lft_comp_s;
  logic signed [15:0] rght_comp_s;

  assign err_sat_s = sat10(ptch);
  assign p_term_s  = {{5{err_sat_s[9]}}, err_sat_s} * P_COEFF;

  // Overflow happens only when both addends have the same sign and the sum's
  // sign differs. In that case the integrator holds its value instead of wrapping.
  assign err_ext_s   = {{8{err_sat_s[9]}}, err_sat_s};
  assign integ_sum_s = integ_r + err_ext_s;
  assign integ_ovf_s = (integ_r[17] == err_ext_s[17]) && (integ_sum_s[17] != integ_r[17]);
  assign i_term_s    = {{3{integ_r[17]}}, integ_r[17:6]};

  assign d_diff_s = {err_sat_s[9], err_sat_s} - {q2_r[9], q2_r};
  assign d_sat_s  = sat7(d_diff_s);
  assign d_term_s = {{6{d_sat_s[6]}}, d_sat_s} * D_COEFF;

  assign pid_s   = {p_term_s[14], p_term_s} + {i_term_s[14], i_term_s}
                 + {{3{d_term_s[12]}}, d_term_s};
  assign steer_s = {{7{ld_cell_diff[11]}}, ld_cell_diff[11:3]};

  // Integrator: rider_off clears it first, and vld accumulates unless the add would overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_r <= 18'sd0;
    end else if (rider_off) begin
      integ_r <= 18'sd0;
    end else if (vld && !integ_ovf_s) begin
      integ_r <= integ_sum_s;
    end else begin
      integ_r <= integ_r;
    end
  end

  // Two-deep error history for the derivative. It shifts on vld even while the rider is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_r <= 10'sd0;
      q2_r <= 10'sd0;
    end else if (vld) begin
      q1_r <= err_sat_s;
      q2_r <= q1_r;
    end else begin
      q1_r <= q1_r;
      q2_r <= q2_r;
    end
  end

  // Steering mix: split the PID torque differentially when steering is enabled.
  always_comb begin
    lft_torque_s  = pid_s;
    rght_torque_s = pid_s;
    if (en_steer) begin
      lft_torque_s  = pid_s - steer_s;
      rght_torque_s = pid_s + steer_s;
    end else begin
      lft_torque_s  = pid_s;
      rght_torque_s = pid_s;
    end
  end

  assign lft_comp_s  = shape(lft_torque_s);
  assign rght_comp_s = shape(rght_torque_s);

  assign lft_rev  = lft_comp_s[15];
  assign lft_spd  = mag11(lft_comp_s);
  assign rght_rev = rght_comp_s[15];
  assign rght_spd = mag11(rght_comp_s);

endmodule

// File: tb/tb_balance_cntrl.sv
// Directed testbench for balance_cntrl. Expected values were worked out by hand
// from the controller equations. Each one is noted next to its step.
module tb_balance_cntrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [15:0] ptch;
  logic [11:0] ld_cell_diff;
  logic        rider_off;
  logic        en_steer;
  logic [10:0] lft_spd;
  logic        lft_rev;
  logic [10:0] rght_spd;
  logic        rght_rev;

  int test_cnt = 0;
  int fail_cnt = 0;

  balance_cntrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .ptch         (ptch),
    .ld_cell_diff (ld_cell_diff),
    .rider_off    (rider_off),
    .en_steer     (en_steer),
    .lft_spd      (lft_spd),
    .lft_rev      (lft_rev),
    .rght_spd     (rght_spd),
    .rght_rev     (rght_rev)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_motors(input string tag, input logic [10:0] ls, input logic lr,
                              input logic [10:0] rs, input logic rr);
    check($sformatf("%s lft_spd", tag), {21'd0, lft_spd}, {21'd0, ls});
    check($sformatf("%s lft_rev", tag), {31'd0, lft_rev}, {31'd0, lr});
    check($sformatf("%s rght_spd", tag), {21'd0, rght_spd}, {21'd0, rs});
    check($sformatf("%s rght_rev", tag), {31'd0, rght_rev}, {31'd0, rr});
  endtask

  // Apply combinational inputs with no state update (vld stays low). Sample at the falling edge.
  task automatic comb_step(input logic [15:0] p, input logic [11:0] ld, input logic es);
    ptch = p;
    ld_cell_diff = ld;
    en_steer = es;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    vld = 1'b0;
    ptch = 16'h0000;
    ld_cell_diff = 12'h000;
    rider_off = 1'b0;
    en_steer = 1'b0;

    // Reset state: ptch = 0 and ld = 0 give zero outputs and a zero integrator.
    @(posedge clk);
    @(negedge clk);
    check_motors("reset", 11'h000, 1'b0, 11'h000, 1'b0);
    check("reset integ", 32'(dut.integ_r), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // P = 70, D = 100, PID = 170 -> 170 + 980 = 1150.
    comb_step(16'h0005, 12'h000, 1'b0);
    check_motors("ptch5", 11'h47E, 1'b0, 11'h47E, 1'b0);
    // PID = -14 - 20 = -34, which is in the band -> -510.
    comb_step(16'hFFFF, 12'h000, 1'b0);
    check_motors("ptchm1", 11'h1FE, 1'b1, 11'h1FE, 1'b1);
    // Saturates to 511: PID = 7154 + 1260 = 8414 -> saturated magnitude.
    comb_step(16'h7FFF, 12'h000, 1'b0);
    check_motors("ptchmax", 11'h7FF, 1'b0, 11'h7FF, 1'b0);
    // Saturates to -512: PID = -7168 - 1280 -> saturated magnitude, reverse.
    comb_step(16'h8000, 12'h000, 1'b0);
    check_motors("ptchmin", 11'h7FF, 1'b1, 11'h7FF, 1'b1);
    // steer = 16: the left torque is -16 -> -240 and the right torque is +16 -> +240.
    comb_step(16'h0000, 12'h080, 1'b1);
    check_motors("steer16", 11'h0F0, 1'b1, 11'h0F0, 1'b0);
    // steer = 70 exactly, so the offset path applies: 70 + 980 = 1050.
    comb_step(16'h0000, 12'h230, 1'b1);
    check_motors("band70", 11'h41A, 1'b1, 11'h41A, 1'b0);
    // steer = 69 is in the band: 69 * 15 = 1035.
    comb_step(16'h0000, 12'h228, 1'b1);
    check_motors("band69", 11'h40B, 1'b1, 11'h40B, 1'b0);
    // Steering disabled: the load cell is ignored and t = 0.
    comb_step(16'h0000, 12'h080, 1'b0);
    check_motors("nosteer", 11'h000, 1'b0, 11'h000, 1'b0);

    // Integrator: 64 samples of 64 -> integ = 4096, I = 64, P = 896, D = 0.
    // This gives PID = 960 -> 1940.
    ld_cell_diff = 12'h000;
    @(posedge clk);
    #1;
    ptch = 16'h0040;
    vld = 1'b1;
    repeat (64) @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    check("integ64", 32'(dut.integ_r), 32'd4096);
    check_motors("integ64", 11'h794, 1'b0, 11'h794, 1'b0);

    // rider_off clears the integrator: PID = 896 -> 1876.
    rider_off = 1'b1;
    @(posedge clk);
    #1 rider_off = 1'b0;
    @(negedge clk);
    check("rider_off integ", 32'(dut.integ_r), 32'd0);
    check_motors("rider_off", 11'h754, 1'b0, 11'h754, 1'b0);

    // rider_off together with vld clears integ and still shifts the queue.
    // Two samples of 10 -> q2 = 10. Then with ptch = 0, D = -200 -> -1180.
    @(posedge clk);
    #1;
    ptch = 16'h000A;
    vld = 1'b1;
    rider_off = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vld = 1'b0;
    rider_off = 1'b0;
    ptch = 16'h0000;
    @(negedge clk);
    check("roff_vld integ", 32'(dut.integ_r), 32'd0);
    check_motors("roff_vld", 11'h49C, 1'b1, 11'h49C, 1'b1);

    // Drive toward the 18b limit with 511 per sample. 256 samples give 130816.
    // The next add would overflow, so the integrator holds there.
    // With ptch = 0 and q2 = 511: I = 2044, D = -1280, PID = 764 -> 1744.
    @(posedge clk);
    #1;
    ptch = 16'h01FF;
    vld = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    vld = 1'b0;
    ptch = 16'h0000;
    @(negedge clk);
    check("integ_sat", 32'(dut.integ_r), 32'd130816);
    check_motors("integ_sat", 11'h6D0, 1'b0, 11'h6D0, 1'b0);

    // Asynchronous reset mid-cycle: state clears without a clock edge.
    // With q2 = 0 and integ = 0, ptch = 5 gives 1150 again.
    @(posedge clk);
    #1;
    ptch = 16'h0005;
    rst_n = 1'b0;
    #1;
    check("async integ", 32'(dut.integ_r), 32'd0);
    check("async q2", 32'(dut.q2_r), 32'd0);
    check_motors("async", 11'h47E, 1'b0, 11'h47E, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/balance_cntrl.md
BALANCE_CNTRL -- requirements
Module: balance_cntrl

Interface
REQ-001 Constants: P_COEFF = 14, P-term gain.
REQ-002 Constants: D_COEFF = 20, D-term gain.
REQ-003 Constants: LOW_TORQUE_BAND = 70, boundary between the low and high torque regions.
REQ-004 Constants: GAIN_MULTIPLIER = 15, gain applied inside the low torque band.
REQ-005 Constants: MIN_DUTY = 980, offset added or subtracted outside the band.
REQ-006 Ports: clk  in  1  sole clock, rising edge.
REQ-007 Ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-008 Ports: vld  in  1  new-pitch-sample strobe.
REQ-009 Ports: ptch  in  16  signed pitch error.
REQ-010 Ports: ld_cell_diff  in  12  signed load-cell difference (steering).
REQ-011 Ports: rider_off  in  1  rider absent; clears integrator.
REQ-012 Ports: en_steer  in  1  steering enable.
REQ-013 Ports: lft_spd  out  11  unsigned left motor magnitude.
REQ-014 Ports: lft_rev  out  1  left reverse.
REQ-015 Ports: rght_spd  out  11  unsigned right motor magnitude.
REQ-016 Ports: rght_rev  out  1  right reverse.

Function
REQ-017 The datapath SHALL be signed two's complement; outputs SHALL be combinational from current inputs plus registered state (no output register).
REQ-018 err_sat (10b signed) SHALL be ptch saturated: ptch > 511 -> 511; ptch < -512 -> -512; else ptch[9:0].
REQ-019 P_term (15b) SHALL be err_sat * P_COEFF.
REQ-020 integ (18b register) SHALL update on each clk edge as follows, in priority order:
- rider_off = 1 -> 0.
- vld = 1 -> integ + sext(err_sat), except hold when both addends have the same sign and the sum's sign differs (overflow).
- else hold.
REQ-021 I_term (15b) SHALL be sext(integ[17:6]).
REQ-022 A two-deep error queue q1/q2 (10b each) SHALL shift on vld (q1 <= err_sat, q2 <= q1) and hold otherwise.
REQ-023 D_diff (11b) SHALL be err_sat - q2.
REQ-024 D_diff SHALL be saturated to 7b signed (+63/-64).
REQ-025 D_term (13b) SHALL be sat(D_diff) * D_COEFF.
REQ-026 PID (16b) SHALL be sext(P_term) + sext(I_term) + sext(D_term).
REQ-027 steer (16b) SHALL be sext(ld_cell_diff[11:3]), i.e. ld_cell_diff >>> 3.
REQ-028 When en_steer = 1: lft_torque = PID - steer and rght_torque = PID + steer; otherwise both torques SHALL equal PID.
REQ-029 Each torque SHALL be shaped independently: if |t| >= LOW_TORQUE_BAND, comp = t + MIN_DUTY for t >= 0, t - MIN_DUTY for t < 0; else comp = t * GAIN_MULTIPLIER (16b).
REQ-030 *_rev SHALL be comp[15].
REQ-031 *_spd SHALL be |comp|, saturated to 0x7FF when |comp| > 2047.
REQ-032 Boundary: |t| = 70 exactly SHALL take the MIN_DUTY path.
REQ-033 Boundary: t = 0 SHALL give spd 0, rev 0.
REQ-034 Simultaneous rider_off and vld SHALL clear integ and still shift the queue.

Reset
REQ-035 Asserting rst_n low SHALL asynchronously clear integ, q1 and q2 to 0.
REQ-036 With ptch = 0 and ld_cell_diff = 0 during reset, all outputs SHALL be 0.
REQ-037 Registers SHALL resume updating at the first rising edge after rst_n deasserts.

Verification
REQ-038 Reset, ptch = 0, ld = 0, en_steer = 0 -> lft_spd = rght_spd = 0, rev = 0.
REQ-039 After reset, ptch = 0x0005, vld = 0 (P = 70, D = 100, PID = 170) -> both spd = 0x47E, rev = 0.
REQ-040 After reset, ptch = 0xFFFF, vld = 0 (PID = -34) -> both spd = 0x1FE, rev = 1.
REQ-041 After reset, ptch = 0x7FFF (saturates to 511, PID = 8414) -> both spd = 0x7FF, rev = 0.
REQ-042 After reset, ptch = 0, en_steer = 1, ld_cell_diff = 0x080 -> lft_spd = 0x0F0, lft_rev = 1; rght_spd = 0x0F0, rght_rev = 0.
REQ-043 Integrator test, ptch = 0x0040, vld = 1:
- after 64 edges, I_term = 64 and PID reflects it;
- one edge with rider_off = 1 -> integ = 0;
- driving integ toward the 18b limit SHALL hold it without wrap.
